// File: rtl/tagged_dispatch.sv
// Tagged in-order distributor: one write stream buffered FIFO-style, head entry steered to the
// output channel named by its tag. Optional out-of-range tag discard enabled by `define TAG_CHECK_EN.
module tagged_dispatch #(
  parameter int NUM_CHANNELS = 4,
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int TAGWIDTH     = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [TAGWIDTH-1:0]     push_tag,
  input  logic [WIDTH-1:0]        data_in,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic [NUM_CHANNELS-1:0] out_vld,
  input  logic [NUM_CHANNELS-1:0] out_rdy,
`ifdef TAG_CHECK_EN
  output logic [7:0]              drop_cnt,
`endif
  output logic [WIDTH-1:0]        data_out
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SLOTS = DEPTH - 1;

  typedef struct packed {
    logic                bad;
    logic [TAGWIDTH-1:0] tag;
    logic [WIDTH-1:0]    data;
  } entry_t;

  entry_t        mem [SLOTS];
  logic [PW:0]   wr_ptr_reg, rd_ptr_reg;
  logic          head_vld_reg;
  entry_t        head_reg;
  logic [CW-1:0] count_reg;

  entry_t push_entry;
  logic   push_ok, pop, discard, head_free, stor_empty, stor_wr;

  // Pointer index runs 0..SLOTS-1; the extra top bit flips on each wrap.
  function automatic logic [PW:0] ptr_inc(input logic [PW:0] p);
    if (p[PW-1:0] == PW'(SLOTS - 1)) return {~p[PW], {PW{1'b0}}};
    return p + (PW+1)'(1);
  endfunction

  assign full       = (count_reg == CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign count      = count_reg;
  assign stor_empty = (rd_ptr_reg == wr_ptr_reg);
  assign push_ok    = push && !full;
  assign data_out   = head_vld_reg ? head_reg.data : '0;

  always_comb begin
    push_entry      = '0;
    push_entry.tag  = push_tag;
    push_entry.data = data_in;
`ifdef TAG_CHECK_EN
    push_entry.bad  = ({1'b0, push_tag} >= (TAGWIDTH+1)'(NUM_CHANNELS));
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_vld
      assign out_vld[gi] = head_vld_reg && !head_reg.bad && (head_reg.tag == TAGWIDTH'(gi));
    end
  endgenerate

  // Only the addressed channel's ready can retire the head.
  assign pop = |(out_vld & out_rdy);
`ifdef TAG_CHECK_EN
  assign discard = head_vld_reg && head_reg.bad;
`else
  assign discard = 1'b0;
`endif
  assign head_free = !head_vld_reg || pop || discard;
  // A push goes to storage unless it bypasses straight into a free head.
  assign stor_wr   = push_ok && !(head_free && stor_empty);

  always_ff @(posedge clk) begin
    if (stor_wr) mem[wr_ptr_reg[PW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      head_vld_reg <= 1'b0;
      head_reg     <= '0;
      count_reg    <= '0;
    end else begin
      if (stor_wr) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (head_free) begin
        if (!stor_empty) begin
          head_vld_reg <= 1'b1;
          head_reg     <= mem[rd_ptr_reg[PW-1:0]];
          rd_ptr_reg   <= ptr_inc(rd_ptr_reg);
        end else if (push_ok) begin
          head_vld_reg <= 1'b1;
          head_reg     <= push_entry;
        end else begin
          head_vld_reg <= 1'b0;
        end
      end
      case ({push_ok, pop || discard})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef TAG_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             drop_cnt <= '0;
    else if (discard && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`else
`ifdef FORMAL
  always_comb begin
    if (!rst && push) assume ({1'b0, push_tag} < (TAGWIDTH+1)'(NUM_CHANNELS));
  end
`endif
`endif

endmodule

// File: tb/tb_tagged_dispatch.sv
// Bench for tagged_dispatch: vector table, hand-written corner sequences and random traffic
// checked against a plain queue model of the whole block (storage plus head).
module tb_tagged_dispatch;
`ifdef TAG_CHECK_EN
  localparam int NC = 3;
`else
  localparam int NC = 4;
`endif
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst, push;
  logic [TW-1:0] push_tag;
  logic [W-1:0]  data_in, data_out;
  logic          full, empty;
  logic [2:0]    count;
  logic [NC-1:0] out_vld, out_rdy;
`ifdef TAG_CHECK_EN
  logic [7:0]    drop_cnt;
`endif

  tagged_dispatch #(.NUM_CHANNELS(NC), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .push(push), .push_tag(push_tag), .data_in(data_in),
    .full(full), .empty(empty), .count(count), .out_vld(out_vld), .out_rdy(out_rdy),
`ifdef TAG_CHECK_EN
    .drop_cnt(drop_cnt),
`endif
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [W-1:0]  data;
  } ment_t;

  ment_t q[$];
  int    m_drop = 0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NC-1:0] m_vld();
    logic [NC-1:0] v = '0;
    if (q.size() != 0 && 32'(q[0].tag) < NC) v[q[0].tag] = 1'b1;
    return v;
  endfunction

  task automatic check_model(input string where);
    chk({where, "_count"}, 32'(count), 32'(q.size()));
    chk({where, "_vld"}, 32'(out_vld), 32'(m_vld()));
    chk({where, "_data"}, 32'(data_out), (q.size() != 0) ? 32'(q[0].data) : 32'd0);
    chk({where, "_full"}, 32'(full), 32'(q.size() == D));
    chk({where, "_empty"}, 32'(empty), 32'(q.size() == 0));
`ifdef TAG_CHECK_EN
    chk({where, "_drop"}, 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // One clock of the whole block: bad head leaves, else addressed ready pops; push if not full.
  task automatic m_step(input logic p, input logic [TW-1:0] t, input logic [W-1:0] d,
                        input logic [NC-1:0] r);
    bit acc = p && (q.size() < D);
    if (q.size() != 0) begin
      if (32'(q[0].tag) >= NC) begin
        void'(q.pop_front());
        if (m_drop < 255) m_drop++;
      end else if (r[q[0].tag]) begin
        void'(q.pop_front());
      end
    end
    if (acc) q.push_back('{t, d});
  endtask

  // Called at a negedge; drives inputs, advances one posedge, lands on the next negedge.
  task automatic cycle(input string where, input logic p, input logic [TW-1:0] t,
                       input logic [W-1:0] d, input logic [NC-1:0] r);
    push = p; push_tag = t; data_in = d; out_rdy = r;
    m_step(p, t, d, r);
    @(posedge clk);
    @(negedge clk);
    check_model(where);
    $display("cyc %-8s push=%0d tag=%0d din=%02h rdy=%b -> vld=%b dout=%02h cnt=%0d",
             where, p, t, d, r, out_vld, data_out, count);
  endtask

  typedef struct {
    logic       p;
    logic [1:0] t;
    logic [7:0] d;
    logic [3:0] r;
    logic [3:0] ev;
    logic [7:0] ed;
    logic [2:0] ec;
  } vec_t;

  vec_t tbl [22];

  initial begin
    rst = 1'b1; push = 1'b1; push_tag = 2'd1; data_in = 8'h5A; out_rdy = '0;
    q.delete(); m_drop = 0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_vld", 32'(out_vld), 0);
    chk("rst_data", 32'(data_out), 0);
    rst = 1'b0; push = 1'b0;
    @(negedge clk);
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_empty", 32'(empty), 1);
    chk("post_rst_vld", 32'(out_vld), 0);

`ifdef TAG_CHECK_EN
    cycle("badtag", 1'b1, 2'd3, 8'h77, '1);
    chk("bad_vld", 32'(out_vld), 0);
    chk("bad_count", 32'(count), 1);
    cycle("goodtag", 1'b1, 2'd0, 8'h01, '1);
    chk("good_vld", 32'(out_vld), 32'b001);
    chk("good_data", 32'(data_out), 32'h01);
    chk("drop_one", 32'(drop_cnt), 1);
    cycle("gooddrn", 1'b0, 2'd0, 8'h00, '1);
    chk("good_gone", 32'(out_vld), 0);
`else
    tbl = '{
      '{1'b1, 2'd2, 8'hA5, 4'b0000, 4'b0100, 8'hA5, 3'd1},
      '{1'b0, 2'd0, 8'h00, 4'b0000, 4'b0100, 8'hA5, 3'd1},
      '{1'b0, 2'd0, 8'h00, 4'b0100, 4'b0000, 8'h00, 3'd0},
      '{1'b1, 2'd0, 8'h01, 4'b0000, 4'b0001, 8'h01, 3'd1},
      '{1'b1, 2'd1, 8'h02, 4'b0000, 4'b0001, 8'h01, 3'd2},
      '{1'b1, 2'd2, 8'h03, 4'b0000, 4'b0001, 8'h01, 3'd3},
      '{1'b1, 2'd3, 8'h04, 4'b0000, 4'b0001, 8'h01, 3'd4},
      '{1'b1, 2'd0, 8'h05, 4'b0000, 4'b0001, 8'h01, 3'd4},
      '{1'b1, 2'd1, 8'h06, 4'b1111, 4'b0010, 8'h02, 3'd3},
      '{1'b0, 2'd0, 8'h00, 4'b1111, 4'b0100, 8'h03, 3'd2},
      '{1'b0, 2'd0, 8'h00, 4'b1111, 4'b1000, 8'h04, 3'd1},
      '{1'b0, 2'd0, 8'h00, 4'b1111, 4'b0000, 8'h00, 3'd0},
      '{1'b1, 2'd1, 8'h33, 4'b0000, 4'b0010, 8'h33, 3'd1},
      '{1'b1, 2'd3, 8'h44, 4'b0010, 4'b1000, 8'h44, 3'd1},
      '{1'b1, 2'd0, 8'h55, 4'b1000, 4'b0001, 8'h55, 3'd1},
      '{1'b0, 2'd0, 8'h00, 4'b0001, 4'b0000, 8'h00, 3'd0},
      '{1'b1, 2'd1, 8'h11, 4'b0001, 4'b0010, 8'h11, 3'd1},
      '{1'b1, 2'd0, 8'h22, 4'b0001, 4'b0010, 8'h11, 3'd2},
      '{1'b0, 2'd0, 8'h00, 4'b0001, 4'b0010, 8'h11, 3'd2},
      '{1'b0, 2'd0, 8'h00, 4'b0011, 4'b0001, 8'h22, 3'd1},
      '{1'b0, 2'd0, 8'h00, 4'b0000, 4'b0001, 8'h22, 3'd1},
      '{1'b0, 2'd0, 8'h00, 4'b0001, 4'b0000, 8'h00, 3'd0}
    };
    for (int i = 0; i < 22; i++) begin
      cycle($sformatf("tbl%0d", i), tbl[i].p, tbl[i].t, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_vld", i), 32'(out_vld), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), 32'(data_out), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].ec == 3'd4));
    end
`endif

    // Reset in the middle of a transfer must discard everything stored.
    for (int i = 0; i < 3; i++) cycle("prerst", 1'b1, 2'(i % NC), 8'hC0 + 8'(i), '0);
    rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_vld", 32'(out_vld), 0);
    q.delete(); m_drop = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("afterrst", 1'b0, 2'd0, 8'h00, '1);
      chk("afterrst_vld", 32'(out_vld), 0);
    end

    // Streaming: one push and one pop every cycle, pointer wraps several times.
    for (int i = 0; i < 20; i++) begin
      cycle("stream", 1'b1, 2'(i % NC), 8'h60 + 8'(i), '1);
      chk("stream_cnt", 32'(count), 1);
    end
    cycle("streamd", 1'b0, 2'd0, 8'h00, '1);

    for (int i = 0; i < 400; i++) begin
      logic [TW-1:0] t;
`ifdef TAG_CHECK_EN
      t = 2'($urandom_range(0, 3));
`else
      t = 2'($urandom_range(0, NC - 1));
`endif
      cycle("rand", ($urandom_range(0, 99) < 60), t, 8'($urandom), NC'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tagged_dispatch.md
Name: tagged_dispatch

Overview:
- Single-input, multi-output distributor: one tagged write stream is buffered in order, then steered to one of NUM_CHANNELS consumers by its tag.
- Each output channel has its own valid/ready handshake; all channels share one data bus.
- Converse of the N-FIFO arbitrated merge: many producers merged to one becomes one producer fanned out to many.
- Used upstream of per-channel FIFOs, and as a formal target with the same scoreboard harness.

Parameters:
- NUM_CHANNELS, 4, number of output channels.
- WIDTH, 8, data width in bits.
- DEPTH, 4, total entry capacity (storage plus output register); power of two, ≥2.
- TAGWIDTH, $clog2(NUM_CHANNELS), tag width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  write request.
- push_tag  input  TAGWIDTH  destination channel of the written word.
- data_in  input  WIDTH  write data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  entries held (storage plus output register).
- out_vld  output  NUM_CHANNELS  one-hot or zero; bit t set when the head entry has tag t.
- out_rdy  input  NUM_CHANNELS  per-channel accept.
- data_out  output  WIDTH  head entry data, shared by all channels.

Behaviour:
- Reset (async, rst high): pointers, count and head-valid cleared.
  - Outputs during and after reset: full=0, empty=1, count=0, out_vld=0, data_out=0.
  - Reset mid-transfer discards all entries; nothing already stored is ever emitted afterwards.
- Storage:
  - Circular buffer of DEPTH-1 entries, each {tag,data}.
  - Read/write pointers carry an extra wrap bit; wrap from DEPTH-2 back to 0.
- Head stage:
  - Registered {head_vld, head_tag, head_data}; out_vld = head_vld ? (1 << head_tag) : 0.
  - data_out = head_data, or 0 when head_vld=0.
- Accepted push: push && !full.
  - Push while full is dropped with no state change, even if a pop occurs in the same cycle.
- Pop: head_vld && out_rdy[head_tag].
  - out_rdy bits of non-addressed channels are ignored.
- Head load: when the head is empty or popping this cycle:
  - storage non-empty: load the oldest storage entry;
  - storage empty and push accepted: load the pushed word directly (bypass);
  - otherwise head_vld <= 0.
- Latency: push accepted at edge t into an empty block gives out_vld at t+1 (one cycle).
- Throughput: one push and one pop per cycle sustained, no bubble.
- count: +1 on accepted push, -1 on pop, unchanged when both occur.
- Ordering: strict FIFO across all tags.
  - Head-of-line blocking: a stalled channel blocks every later entry, regardless of tag.
- Simultaneous push and pop with count==1: the pushed word bypasses into the head; count stays 1.
- Tag range: if NUM_CHANNELS is not a power of two, tags ≥ NUM_CHANNELS are handled by the optional feature. Without it they are illegal input, constrained by the harness.
- out_vld and data_out hold stable while head_vld=1 and no pop occurs.

Optional Feature:
- Macro TAG_CHECK_EN.
- Defined:
  - A push with push_tag ≥ NUM_CHANNELS is accepted (counts as a push for full) but marked bad.
  - A bad entry reaching the head is discarded the next cycle without asserting any out_vld.
  - Extra output port drop_cnt (8 bits, saturating at 255, reset 0) increments per discarded entry.
- Undefined:
  - No drop_cnt port.
  - Out-of-range tags are not stored specially; under `FORMAL an assumption forbids them.
  - Only the low TAGWIDTH bits are decoded.

Test Plan:
- Reset state:
  - Stimulus: rst high for 2 cycles with push=1.
  - Response: count=0, empty=1, out_vld=0; rst low with no push keeps these values.
- Single transfer:
  - Stimulus: push tag=2, data=0xA5, out_rdy=0.
  - Response: next cycle out_vld=4'b0100, data_out=0xA5, count=1; stable until out_rdy[2]=1, then out_vld=0, count=0.
- Fill and overflow:
  - Stimulus: out_rdy=0; push 5 words (tags 0,1,2,3,0; data 1..5).
  - Response: full after the 4th push, 5th dropped, count=4; then all out_rdy=1 drains 1,2,3,4 in order on vld 0001, 0010, 0100, 1000.
- Head-of-line blocking:
  - Stimulus: push tag1 data 0x11, then tag0 data 0x22; out_rdy=4'b0001.
  - Response: out_vld=0010 held, tag0 word not emitted; raising out_rdy[1] emits 0x11, then 0x22 on 0001 next cycle.
- Streaming:
  - Stimulus: continuous push with tag = cycle mod 4, all out_rdy=1, 20 cycles.
  - Response: count stays 1, one pop per cycle, data order preserved, pointer wrap exercised.
- TAG_CHECK_EN with NUM_CHANNELS=3:
  - Stimulus: push tag=3 data 0x77, then tag=0 data 0x01.
  - Response: 0x77 never appears on any out_vld, drop_cnt=1; 0x01 emitted on out_vld=001.
